// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
//   Shared constants for the memory arbiter.
//   ARB_FIXED / ARB_RR : values for the arbiter MODE parameter.
//   arb_state_e        : arbiter FSM state encoding (IDLE / BUSY).
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
//   Combinational masked priority pick. It scans the active vector starting at
//   index 'start' and wrapping around, and returns the first set index.
//   Ports:
//     act   in  NREQ  candidate vector
//     start in  IDXW  scan start index (tie to 0 for plain fixed priority)
//     valid out 1     some candidate was found
//     idx   out IDXW  index of the chosen candidate (0 when none)
// -----------------------------------------------------------------------------
module rr_picker #(
    parameter int NREQ = 2,
    parameter int IDXW = 3
) (
    input  logic [NREQ-1:0] act,
    input  logic [IDXW-1:0] start,
    output logic            valid,
    output logic [IDXW-1:0] idx
);

    always_comb begin
        int j;
        valid = 1'b0;
        idx   = '0;
        j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(start) + k) % NREQ;
            // Inner loop keeps every bit select a constant after unrolling.
            for (int i = 0; i < NREQ; i++) begin
                if (!valid && (i == j) && act[i]) begin
                    valid = 1'b1;
                    idx   = IDXW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/mem_arbiter_n.sv
// -----------------------------------------------------------------------------
// mem_arbiter_n
//   Multiplexes NREQ requesters onto one external memory port. The winner is
//   picked combinationally (fixed priority or round-robin) and drives the port
//   in the same cycle. If memory stalls (mdelay=1) the grant is locked to the
//   owner until the first cycle with mdelay=0. A kill of the owner's read while
//   the bus is held drains the transaction and suppresses its completion.
//   Ports:
//     clk, rst                 clock, asynchronous active-low reset
//     req_addr/we/re/sel/kill  per-requester request bundle (slice i)
//     mdelay                   memory not ready
//     AddrOut/we/re/sel        memory port (all zero when nothing is granted)
//     grant                    one-hot grant
//     delay                    per-requester stall
//     owner                    index of the current bus owner
//     stall_kill               high while a killed read drains
// -----------------------------------------------------------------------------
module mem_arbiter_n
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NREQ  = 2,
    parameter int MODE  = 0,
    parameter int IDXW  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ*WIDTH-1:0] req_addr,
    input  logic [NREQ-1:0]       req_we,
    input  logic [NREQ-1:0]       req_re,
    input  logic [2*NREQ-1:0]     req_sel,
    input  logic [NREQ-1:0]       req_kill,
    input  logic                  mdelay,
    output logic [WIDTH-1:0]      AddrOut,
    output logic                  we,
    output logic                  re,
    output logic [1:0]            sel,
    output logic [NREQ-1:0]       grant,
    output logic [NREQ-1:0]       delay,
    output logic [IDXW-1:0]       owner,
    output logic                  stall_kill
);

    arb_state_e       state_q, state_d;
    logic [IDXW-1:0]  owner_q, owner_d;
    logic [IDXW-1:0]  rr_ptr_q, rr_ptr_d;
    logic             drain_q, drain_d;

    // Copy of the owner's request taken at BUSY entry; the bus is driven from
    // it while stalled so a draining owner can already present a new request.
    logic [WIDTH-1:0] hold_addr_q, hold_addr_d;
    logic [1:0]       hold_sel_q, hold_sel_d;
    logic             hold_we_q, hold_we_d;
    logic             hold_re_q, hold_re_d;

    logic [NREQ-1:0]  active, cand;
    logic [IDXW-1:0]  pick_start, win_idx;
    logic             win_vld;
    logic [WIDTH-1:0] win_addr;
    logic [1:0]       win_sel;
    logic             win_we, win_re;

    logic             cur_vld;
    logic [IDXW-1:0]  cur_idx;
    logic [WIDTH-1:0] cur_addr;
    logic [1:0]       cur_sel;
    logic             cur_we, cur_re;
    logic             kill_now, suppress;

    function automatic logic [IDXW-1:0] next_ptr(input logic [IDXW-1:0] idx);
        if (idx == IDXW'(NREQ - 1)) return '0;
        return idx + IDXW'(1);
    endfunction

    assign pick_start = (MODE == ARB_RR) ? rr_ptr_q : '0;

    rr_picker #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_pick (
        .act   (cand),
        .start (pick_start),
        .valid (win_vld),
        .idx   (win_idx)
    );

    // Winner's request bundle.
    always_comb begin
        win_addr = '0;
        win_sel  = '0;
        win_we   = 1'b0;
        win_re   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_idx == IDXW'(i)) begin
                win_addr = req_addr[i*WIDTH +: WIDTH];
                win_sel  = req_sel[2*i +: 2];
                win_we   = req_we[i];
                win_re   = req_re[i];
            end
        end
    end

    // A kill only matters against the held read; a held write always completes.
    always_comb begin
        kill_now = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if ((state_q == ARB_BUSY) && (owner_q == IDXW'(i)))
                kill_now = req_kill[i] & hold_re_q;
        end
        suppress = drain_q | kill_now;
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        drain_d     = drain_q;
        hold_addr_d = hold_addr_q;
        hold_sel_d  = hold_sel_q;
        hold_we_d   = hold_we_q;
        hold_re_d   = hold_re_q;
        cur_vld     = 1'b0;
        cur_idx     = owner_q;
        cur_addr    = hold_addr_q;
        cur_sel     = hold_sel_q;
        cur_we      = hold_we_q;
        cur_re      = hold_re_q;

        if (state_q == ARB_BUSY) begin
            cur_vld = 1'b1;
        end else if (win_vld) begin
            cur_vld     = 1'b1;
            cur_idx     = win_idx;
            cur_addr    = win_addr;
            cur_sel     = win_sel;
            cur_we      = win_we;
            cur_re      = win_re;
            hold_addr_d = win_addr;
            hold_sel_d  = win_sel;
            hold_we_d   = win_we;
            hold_re_d   = win_re;
        end

        if (cur_vld) begin
            owner_d = cur_idx;
            if (mdelay) begin
                state_d = ARB_BUSY;
                drain_d = suppress;
            end else begin
                // The bus is released here; the next winner is picked next cycle.
                state_d = ARB_IDLE;
                drain_d = 1'b0;
                if (MODE == ARB_RR) rr_ptr_d = next_ptr(cur_idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ARB_IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            drain_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            drain_q  <= drain_d;
        end
    end

    always_ff @(posedge clk) begin
        hold_addr_q <= hold_addr_d;
        hold_sel_q  <= hold_sel_d;
        hold_we_q   <= hold_we_d;
        hold_re_q   <= hold_re_d;
    end

    // Outputs are forced to zero while reset is asserted, even mid-transaction.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
        logic granted;
        assign active[gi] = req_we[gi] | req_re[gi];
        assign cand[gi]   = active[gi] & ~(req_kill[gi] & req_re[gi]);
        assign granted    = cur_vld & (cur_idx == IDXW'(gi));
        assign grant[gi]  = rst & granted;
        assign delay[gi]  = rst & (granted ? (mdelay | suppress) : active[gi]);
    end

    assign AddrOut    = (rst && cur_vld) ? cur_addr : '0;
    assign sel        = (rst && cur_vld) ? cur_sel : '0;
    assign we         = rst & cur_vld & cur_we;
    assign re         = rst & cur_vld & cur_re;
    assign owner      = rst ? cur_idx : '0;
    assign stall_kill = rst & suppress;

endmodule
